// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the receiver here and by a future transmitter.
//   DATA_BITS    : payload bits per frame (8N1 framing)
//   uart_state_e : frame sequencer states, IDLE -> START -> DATA -> STOP
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver and its line / byte consumer.
//   rx        : serial line into the receiver (idle high)
//   ready     : consumer accepts data when valid && ready
//   data      : last received byte
//   valid     : data holds an unconsumed byte
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, new byte landed while valid was still high
// modport master : line driver / consumer side
// modport slave  : receiver side
interface uart_rx_if;

    logic                           rx;
    logic                           ready;
    logic [uart_pkg::DATA_BITS-1:0] data;
    logic                           valid;
    logic                           frame_err;
    logic                           overrun;

    modport master (
        output rx,
        output ready,
        input  data,
        input  valid,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  rx,
        input  ready,
        output data,
        output valid,
        output frame_err,
        output overrun
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk, rst_n : clock and asynchronous active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized output (both flops reset to RESET_VAL)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready byte output.
//   CLKS_PER_BIT : clock cycles per serial bit (4..4096)
//   clk, rst_n   : clock and asynchronous active-low reset
//   bus          : uart_rx_if.slave (rx, ready in; data, valid, frame_err, overrun out)
// Start bit is re-checked at its midpoint; data and stop bits are sampled one
// bit time apart from there, i.e. near the middle of each bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_rx_if.slave   bus
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]        BIT_LAST = 3'(DATA_BITS - 1);

    logic                 rx_s;

    uart_state_e          state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 fe_q,      fe_d;
    logic                 ov_q,      ov_d;

    logic                 cnt_last;
    logic                 cnt_mid;
    logic                 stop_done;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.rx),
        .q_o   (rx_s)
    );

    assign cnt_last  = (cnt_q == CNT_LAST);
    assign cnt_mid   = (cnt_q == CNT_MID);
    assign stop_done = (state_q == STOP) && cnt_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!rx_s) state_d = START;
            // A line that is high again at mid start bit was only a glitch.
            START: if (cnt_mid) state_d = rx_s ? IDLE : DATA;
            DATA:  if (cnt_last && (bit_idx_q == BIT_LAST)) state_d = STOP;
            STOP:  if (cnt_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        fe_d      = 1'b0;
        ov_d      = 1'b0;

        case (state_q)
            IDLE:  cnt_d = '0;
            START: cnt_d = cnt_mid ? '0 : cnt_q + 1'b1;
            DATA: begin
                if (cnt_last) begin
                    cnt_d     = '0;
                    // LSB arrives first, so shifting right leaves it in bit 0.
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    // Wraps back to 0 after the last bit, ready for the next frame.
                    bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP:  cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
            default: cnt_d = '0;
        endcase

        if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end

        // A good stop bit wins over a same-cycle consume; it is only an
        // overrun when the previous byte was still unconsumed.
        if (stop_done) begin
            if (rx_s) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ov_d    = valid_q && !bus.ready;
            end else begin
                fe_d = 1'b1;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = fe_q;
    assign bus.overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 16 clocks/bit, one at 4 clocks/bit.
module tb_uart_rx;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_rx_if if16 ();
    uart_rx_if if4 ();

    uart_rx #(.CLKS_PER_BIT(16)) u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    uart_rx #(.CLKS_PER_BIT(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Event monitors, sampled on the falling edge away from DUT updates.
    int          vrise16 = 0, fe16 = 0, ov16 = 0, start16 = 0, data16 = 0;
    int          vrise4 = 0, fe4 = 0, ov4 = 0;
    logic [7:0]  last16 = 8'h00;
    logic [7:0]  rec4 [0:7];
    logic        vprev16 = 1'b0, vprev4 = 1'b0;
    uart_state_e sprev16 = IDLE;

    always @(negedge clk) begin
        vprev16 <= if16.valid;
        vprev4  <= if4.valid;
        sprev16 <= u16.state_q;
        if (if16.valid && !vprev16) begin
            vrise16 <= vrise16 + 1;
            last16  <= if16.data;
        end
        if (if4.valid && !vprev4) begin
            rec4[vrise4[2:0]] <= if4.data;
            vrise4 <= vrise4 + 1;
        end
        if (if16.frame_err) fe16 <= fe16 + 1;
        if (if16.overrun)   ov16 <= ov16 + 1;
        if (if4.frame_err)  fe4  <= fe4 + 1;
        if (if4.overrun)    ov4  <= ov4 + 1;
        if (u16.state_q == START && sprev16 != START) start16 <= start16 + 1;
        if (u16.state_q == DATA  && sprev16 != DATA)  data16  <= data16 + 1;
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_rx(input int cpb, input logic v);
        if (cpb == 16) if16.rx = v;
        else           if4.rx  = v;
    endtask

    // Full 8N1 frame. A bad stop bit is held low just past its midpoint and
    // then released, so the tail does not look like a fresh start bit.
    task automatic send_frame(input int cpb, input logic [7:0] b, input bit good_stop);
        drive_rx(cpb, 1'b0);
        hold(cpb);
        for (int i = 0; i < 8; i++) begin
            drive_rx(cpb, b[i]);
            hold(cpb);
        end
        if (good_stop) begin
            drive_rx(cpb, 1'b1);
            hold(cpb);
        end else begin
            drive_rx(cpb, 1'b0);
            hold(cpb / 2 + 2);
            drive_rx(cpb, 1'b1);
            hold(cpb - cpb / 2 - 2);
        end
    endtask

    task automatic test_reset;
        hold(3);
        n_cmp++; if (if16.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid16: got %b want 0", if16.valid); end
        n_cmp++; if (if16.data !== 8'h00) begin n_err++; $display("FAIL reset_data16: got %h want 00", if16.data); end
        n_cmp++; if (if16.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_fe16: got %b want 0", if16.frame_err); end
        n_cmp++; if (if16.overrun !== 1'b0) begin n_err++; $display("FAIL reset_ov16: got %b want 0", if16.overrun); end
        n_cmp++; if (if4.valid !== 1'b0 || if4.data !== 8'h00) begin n_err++; $display("FAIL reset_out4: got v=%b d=%h want v=0 d=00", if4.valid, if4.data); end
        n_cmp++; if (u16.state_q !== IDLE) begin n_err++; $display("FAIL reset_state16: got %0d want IDLE", u16.state_q); end
        rst_n = 1'b1;
        hold(4);
    endtask

    task automatic test_good_byte;
        int v0 = vrise16, f0 = fe16, o0 = ov16;
        if16.ready = 1'b1;
        send_frame(16, 8'hA5, 1'b1);
        hold(4);
        n_cmp++; if (vrise16 - v0 !== 1) begin n_err++; $display("FAIL good_vpulses: got %0d want 1", vrise16 - v0); end
        n_cmp++; if (last16 !== 8'hA5) begin n_err++; $display("FAIL good_data: got %h want a5", last16); end
        n_cmp++; if (fe16 - f0 !== 0 || ov16 - o0 !== 0) begin n_err++; $display("FAIL good_errs: got fe=%0d ov=%0d want 0 0", fe16 - f0, ov16 - o0); end
        n_cmp++; if (if16.valid !== 1'b0) begin n_err++; $display("FAIL good_consumed: got %b want 0", if16.valid); end
    endtask

    task automatic test_frame_err;
        int v0 = vrise16, f0 = fe16;
        send_frame(16, 8'h3C, 1'b0);
        hold(30);
        n_cmp++; if (fe16 - f0 !== 1) begin n_err++; $display("FAIL ferr_pulses: got %0d want 1", fe16 - f0); end
        n_cmp++; if (vrise16 - v0 !== 0 || if16.valid !== 1'b0) begin n_err++; $display("FAIL ferr_valid: got rises=%0d v=%b want 0 0", vrise16 - v0, if16.valid); end
        n_cmp++; if (if16.data !== 8'hA5) begin n_err++; $display("FAIL ferr_data: got %h want a5", if16.data); end
    endtask

    task automatic test_overrun;
        int v0 = vrise16, o0 = ov16, f0 = fe16;
        if16.ready = 1'b0;
        send_frame(16, 8'h11, 1'b1);
        n_cmp++; if (if16.data !== 8'h11 || if16.valid !== 1'b1) begin n_err++; $display("FAIL ovr_first: got d=%h v=%b want 11 1", if16.data, if16.valid); end
        send_frame(16, 8'h22, 1'b1);
        hold(4);
        n_cmp++; if (if16.data !== 8'h22) begin n_err++; $display("FAIL ovr_data: got %h want 22", if16.data); end
        n_cmp++; if (if16.valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", if16.valid); end
        n_cmp++; if (ov16 - o0 !== 1) begin n_err++; $display("FAIL ovr_pulses: got %0d want 1", ov16 - o0); end
        n_cmp++; if (vrise16 - v0 !== 1 || fe16 - f0 !== 0) begin n_err++; $display("FAIL ovr_counts: got rises=%0d fe=%0d want 1 0", vrise16 - v0, fe16 - f0); end
        if16.ready = 1'b1;
        hold(2);
        n_cmp++; if (if16.valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain: got %b want 0", if16.valid); end
    endtask

    task automatic test_glitch;
        int v0 = vrise16, f0 = fe16, o0 = ov16, s0 = start16, d0 = data16;
        if16.rx = 1'b0;
        hold(5);
        if16.rx = 1'b1;
        hold(30);
        n_cmp++; if (start16 - s0 !== 1) begin n_err++; $display("FAIL glitch_start: got %0d want 1", start16 - s0); end
        n_cmp++; if (data16 - d0 !== 0) begin n_err++; $display("FAIL glitch_data_state: got %0d want 0", data16 - d0); end
        n_cmp++; if (vrise16 - v0 !== 0 || fe16 - f0 !== 0 || ov16 - o0 !== 0) begin n_err++; $display("FAIL glitch_outputs: got v=%0d fe=%0d ov=%0d want 0 0 0", vrise16 - v0, fe16 - f0, ov16 - o0); end
        n_cmp++; if (u16.state_q !== IDLE) begin n_err++; $display("FAIL glitch_idle: got %0d want IDLE", u16.state_q); end
    endtask

    task automatic test_reset_midframe;
        int v0 = vrise16;
        if16.rx = 1'b0;
        hold(16);
        if16.rx = 1'b1;          // bits 0..3 of 8'hFF, then into bit 4
        hold(4 * 16 + 8);
        rst_n = 1'b0;
        hold(3);
        rst_n = 1'b1;
        hold(120);               // rest of the aborted frame stays high
        n_cmp++; if (vrise16 - v0 !== 0 || if16.valid !== 1'b0) begin n_err++; $display("FAIL rstmid_novalid: got rises=%0d v=%b want 0 0", vrise16 - v0, if16.valid); end
        n_cmp++; if (if16.data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h want 00", if16.data); end
        send_frame(16, 8'h0F, 1'b1);
        hold(4);
        n_cmp++; if (vrise16 - v0 !== 1 || last16 !== 8'h0F) begin n_err++; $display("FAIL rstmid_deliver: got rises=%0d d=%h want 1 0f", vrise16 - v0, last16); end
    endtask

    task automatic test_back_to_back;
        int v0 = vrise4, f0 = fe4, o0 = ov4;
        if4.ready = 1'b1;
        send_frame(4, 8'h80, 1'b1);
        send_frame(4, 8'h01, 1'b1);
        hold(4);
        n_cmp++; if (vrise4 - v0 !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", vrise4 - v0); end
        n_cmp++; if (rec4[v0[2:0]] !== 8'h80) begin n_err++; $display("FAIL b2b_first: got %h want 80", rec4[v0[2:0]]); end
        n_cmp++; if (rec4[3'(v0 + 1)] !== 8'h01) begin n_err++; $display("FAIL b2b_second: got %h want 01", rec4[3'(v0 + 1)]); end
        n_cmp++; if (fe4 - f0 !== 0 || ov4 - o0 !== 0) begin n_err++; $display("FAIL b2b_errs: got fe=%0d ov=%0d want 0 0", fe4 - f0, ov4 - o0); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rec4[i] = 8'h00;
        if16.rx    = 1'b1;
        if16.ready = 1'b1;
        if4.rx     = 1'b1;
        if4.ready  = 1'b1;
        test_reset();
        test_good_byte();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 4..4096.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 SHALL have port data, output, 8 bits: last received byte.
REQ-006 SHALL have port valid, output, 1 bit: data holds an unconsumed byte.
REQ-007 SHALL have port ready, input, 1 bit: consumer accepts data when valid && ready.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port overrun, output, 1 bit: one-cycle pulse; a new byte arrived while valid was still high.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use; the synchronized signal is rx_s.
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 IDLE: SHALL go to START on the first cycle rx_s==0 and clear the baud counter.
REQ-013 START: at counter == CLKS_PER_BIT/2-1 (mid start bit), rx_s==0 SHALL go to DATA and clear the counter; rx_s==1 SHALL return to IDLE (glitch reject) with no output change.
REQ-014 DATA: each time the counter reaches CLKS_PER_BIT-1, SHALL shift rx_s into bit 7 of an 8-bit shift register (right shift), clear the counter and increment a 3-bit bit index; after the 8th sample SHALL go to STOP.
REQ-015 STOP: at counter == CLKS_PER_BIT-1, SHALL return to IDLE; if rx_s==1, SHALL load data from the shift register and set valid on the next edge; if rx_s==0, SHALL pulse frame_err for one cycle and leave data/valid unchanged.
REQ-016 Latency: valid SHALL rise 1 cycle after the mid-stop-bit sample, i.e. about 9.5 bit times + 2 synchronizer cycles after the falling start edge.
REQ-017 valid SHALL clear on the cycle after any edge where valid && ready; data SHALL remain stable while valid is high.
REQ-018 If a good stop bit completes while valid==1 and ready==0, SHALL overwrite data, keep valid=1 and pulse overrun for one cycle.
REQ-019 If a good stop bit completes in the same cycle as valid && ready, SHALL load the new byte, keep valid=1 and not pulse overrun.
REQ-020 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count up from 0 and never wrap beyond CLKS_PER_BIT-1.
REQ-021 After STOP, IDLE SHALL accept a new start edge on the very next cycle (back-to-back frames).

Reset
REQ-022 While rst_n==0: state=IDLE, counter=0, bit index=0, shift register=0, data=8'h00, valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame and discard the partial byte; after release the receiver SHALL wait in IDLE for a fresh falling edge.

Structure
REQ-024 SHALL place the state enum (IDLE/START/DATA/STOP) and the constant DATA_BITS=8 in shared package uart_pkg, which a future uart_tx also uses.
REQ-025 SHALL instantiate the 2-flop synchronizer as sub-module sync_2ff (1-bit, parameterized reset value).

Verification
REQ-026 CLKS_PER_BIT=16, ready=1, send 8'hA5 with a good stop bit -> valid pulses once with data=8'hA5; frame_err=0 and overrun=0.
REQ-027 Send 8'h3C with the stop bit driven low -> frame_err pulses once, valid stays 0, data keeps its prior value.
REQ-028 ready=0, send 8'h11 then 8'h22 back-to-back -> after the second frame data=8'h22, valid=1, one overrun pulse.
REQ-029 Drive a 5-cycle low glitch on rx while idle -> no state beyond START, valid=0, no error pulses.
REQ-030 Assert rst_n low during bit 4 of 8'hFF, release, then send 8'h0F -> only 8'h0F is delivered.
REQ-031 CLKS_PER_BIT=4, send 8'h80 and 8'h01 back-to-back with ready=1 -> two valid pulses, in order, with correct data.
